// File: rtl/booth_div_seq.sv
// Sequential signed divider: restoring radix-2 on magnitudes, one quotient bit per clock, then sign fixup.
// Optional result self-check enabled by defining DIV_SELF_CHECK_EN.
module booth_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             check_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_ZERO, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] qm_q, qm_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH+1:0] p_sh;
  logic             p_ge;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_ext, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Dividend magnitude is exact as an unsigned WIDTH-bit value, including the most-negative input.
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_ext = {divisor[WIDTH-1], divisor};
    dvs_mag = dvs_ext[WIDTH] ? (~dvs_ext + 1'b1) : dvs_ext;
    p_sh    = {p_q, qm_q[WIDTH-1]};
    p_ge    = (p_sh >= {1'b0, dvs_q});
    quo_fix = q_neg_q ? (~qm_q + 1'b1) : qm_q;
    rem_fix = r_neg_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    dvs_d      = dvs_q;
    qm_d       = qm_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    ovf_pend_d = ovf_pend_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          q_neg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg_d    = dividend[WIDTH-1];
          qm_d       = dvd_mag;
          dvs_d      = dvs_mag;
          dvd_d      = dividend;
          p_d        = '0;
          cnt_d      = CNT_INIT;
          ovf_pend_d = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
          state_d    = (divisor == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        p_d  = p_ge ? (WIDTH+1)'(p_sh - {1'b0, dvs_q}) : p_sh[WIDTH:0];
        qm_d = {qm_q[WIDTH-2:0], p_ge};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        quo_d   = quo_fix;
        rem_d   = rem_fix;
        dbz_d   = 1'b0;
        ovf_d   = ovf_pend_q;
        state_d = S_DONE;
      end
      S_ZERO: begin
        quo_d   = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        ovf_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      dvs_q      <= '0;
      qm_q       <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      dvs_q      <= dvs_d;
      qm_q       <= qm_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      ovf_pend_q <= ovf_pend_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

`ifdef DIV_SELF_CHECK_EN
  logic           chk_q, chk_d;
  logic [WIDTH:0] rem_ext, rem_mag;
  logic           rule_mag, rule_rsign, rule_qsign;

  // The quotient-sign rule only applies with a real divisor; the -1 returned for x/0 is a convention.
  always_comb begin
    rem_ext    = {rem_fix[WIDTH-1], rem_fix};
    rem_mag    = rem_ext[WIDTH] ? (~rem_ext + 1'b1) : rem_ext;
    rule_mag   = (rem_mag < dvs_q);
    rule_rsign = (rem_fix == '0) || (rem_fix[WIDTH-1] == r_neg_q);
    rule_qsign = (quo_fix == '0) || ovf_pend_q || (quo_fix[WIDTH-1] == q_neg_q);
    chk_d      = chk_q;
    case (state_q)
      S_FIX:   chk_d = !(rule_mag && rule_rsign && rule_qsign);
      S_ZERO:  chk_d = !((dvd_q == '0) || (dvd_q[WIDTH-1] == r_neg_q));
      S_DONE:  if (out_ready) chk_d = 1'b0;
      default: chk_d = chk_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) chk_q <= 1'b0;
    else     chk_q <= chk_d;
  end

  assign check_err = chk_q;
`else
  assign check_err = 1'b0;
`endif

endmodule
